// File: rtl/flash_cmd_dispatcher.sv
// flash_cmd_dispatcher
//   Consumer of the 32-bit command word stream (cmd + start_cmd). Decodes
//   opcode/sub-index words, assembles 24-bit flash addresses and issues a
//   single read, write or erase request to the NAND flash controller over a
//   req/ack/done handshake. Malformed sequences, words arriving while busy
//   and stalled partial sequences are flagged.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   cmd[31:0]        [31:24] opcode, [23:16] sub-index, [15:0] payload
//   start_cmd        word strobe; only its rising edge counts
//   flash_ack        controller accepted the request (1-cycle pulse)
//   flash_done       controller finished the request (1-cycle pulse)
//   req_valid        request pending, held until flash_ack
//   req_op[1:0]      01 write, 10 read, 11 erase, 00 idle
//   req_addr[23:0]   start (or only) address
//   req_end_addr     erase end address, 0 for read/write
//   busy             request issued and not yet done
//   cmd_err          1-cycle pulse, err_code valid with it
//   err_code[1:0]    01 unknown/out-of-order, 10 rejected busy, 11 erase end<start
//   seq_timeout      1-cycle pulse, partial sequence abandoned
//
// state | meaning
// IDLE  | waiting for the first word of a sequence
// RD1   | read address upper bits held, expecting AD_01
// WR1   | write address upper bits held, expecting AF_01
// ER1   | erase start upper bits held, expecting AE_01
// ER2   | erase start complete, expecting AE_02
// ER3   | erase end upper bits held, expecting AE_03
// REQ   | request presented, waiting for flash_ack
// BUSY  | request accepted, waiting for flash_done
module flash_cmd_dispatcher #(
  parameter int          TIMEOUT_CYC = 24000,
  parameter logic [7:0]  OP_WADDR    = 8'hAF,
  parameter logic [7:0]  OP_RADDR    = 8'hAD,
  parameter logic [7:0]  OP_ERASE    = 8'hAE,
  parameter logic [7:0]  OP_WGO      = 8'hA0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmd,
  input  logic        start_cmd,
  input  logic        flash_ack,
  input  logic        flash_done,
  output logic        req_valid,
  output logic [1:0]  req_op,
  output logic [23:0] req_addr,
  output logic [23:0] req_end_addr,
  output logic        busy,
  output logic        cmd_err,
  output logic [1:0]  err_code,
  output logic        seq_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD1, S_WR1, S_ER1, S_ER2, S_ER3, S_REQ, S_BUSY
  } state_t;

  localparam int            TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

  state_t state, state_nxt;

  logic        start_cmd_d, word_vld;
  logic [31:0] word_q;
  logic [15:0] hdr, pay, exp_hdr;

  logic [23:0] seq_addr, seq_addr_nxt;
  logic [15:0] end_hi, end_hi_nxt;
  logic [23:0] wr_addr, wr_addr_nxt;
  logic        wr_addr_valid, wr_valid_nxt;
  logic [23:0] end_full;
  logic [1:0]  req_op_nxt;
  logic [23:0] req_addr_nxt, req_end_nxt;
  logic        err_nxt, tmo_nxt;
  logic [1:0]  err_code_nxt;

  logic [TW-1:0] tmr;
  logic          in_seq, tmr_tc;

  assign hdr      = word_q[31:16];
  assign pay      = word_q[15:0];
  assign in_seq   = state inside {S_RD1, S_WR1, S_ER1, S_ER2, S_ER3};
  assign tmr_tc   = in_seq && (tmr == TMR_LAST);
  assign end_full = {end_hi, pay[15:8]};

  assign req_valid = (state == S_REQ);
  assign busy      = (state == S_REQ) || (state == S_BUSY);

  // Word capture: one word per rising edge of start_cmd, decoded next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_cmd_d <= 1'b0;
      word_vld    <= 1'b0;
      word_q      <= '0;
    end else begin
      start_cmd_d <= start_cmd;
      word_vld    <= start_cmd & ~start_cmd_d;
      if (start_cmd & ~start_cmd_d)
        word_q <= cmd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // A word seen on the terminal-count cycle clears the timer, so it wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              tmr <= '0;
    else if (in_seq && !word_vld && !tmr_tc) tmr <= tmr + TW'(1);
    else                                  tmr <= '0;
  end

  always_comb begin
    exp_hdr = 16'h0000;
    case (state)
      S_RD1:   exp_hdr = {OP_RADDR, 8'h01};
      S_WR1:   exp_hdr = {OP_WADDR, 8'h01};
      S_ER1:   exp_hdr = {OP_ERASE, 8'h01};
      S_ER2:   exp_hdr = {OP_ERASE, 8'h02};
      S_ER3:   exp_hdr = {OP_ERASE, 8'h03};
      default: exp_hdr = 16'h0000;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    err_nxt      = 1'b0;
    err_code_nxt = 2'b00;
    tmo_nxt      = 1'b0;
    seq_addr_nxt = seq_addr;
    end_hi_nxt   = end_hi;
    wr_addr_nxt  = wr_addr;
    wr_valid_nxt = wr_addr_valid;
    req_op_nxt   = req_op;
    req_addr_nxt = req_addr;
    req_end_nxt  = req_end_addr;

    case (state)
      S_IDLE: begin
        if (word_vld) begin
          if (hdr == {OP_RADDR, 8'h00}) begin
            state_nxt          = S_RD1;
            seq_addr_nxt[23:8] = pay;
          end else if (hdr == {OP_WADDR, 8'h00}) begin
            state_nxt          = S_WR1;
            seq_addr_nxt[23:8] = pay;
          end else if (hdr == {OP_ERASE, 8'h00}) begin
            state_nxt          = S_ER1;
            seq_addr_nxt[23:8] = pay;
          end else if (hdr == {OP_WGO, 8'h00} && wr_addr_valid) begin
            state_nxt    = S_REQ;
            req_op_nxt   = 2'b01;
            req_addr_nxt = wr_addr;
            req_end_nxt  = '0;
            wr_valid_nxt = 1'b0;
          end else begin
            err_nxt      = 1'b1;
            err_code_nxt = 2'b01;
          end
        end
      end

      S_RD1, S_WR1, S_ER1, S_ER2, S_ER3: begin
        if (word_vld) begin
          if (hdr != exp_hdr) begin
            // Out-of-sequence word is rejected, not restarted as a new sequence.
            state_nxt    = S_IDLE;
            err_nxt      = 1'b1;
            err_code_nxt = 2'b01;
          end else begin
            case (state)
              S_RD1: begin
                state_nxt    = S_REQ;
                req_op_nxt   = 2'b10;
                req_addr_nxt = {seq_addr[23:8], pay[15:8]};
                req_end_nxt  = '0;
              end
              S_WR1: begin
                state_nxt    = S_IDLE;
                wr_addr_nxt  = {seq_addr[23:8], pay[15:8]};
                wr_valid_nxt = 1'b1;
              end
              S_ER1: begin
                state_nxt         = S_ER2;
                seq_addr_nxt[7:0] = pay[15:8];
              end
              S_ER2: begin
                state_nxt  = S_ER3;
                end_hi_nxt = pay;
              end
              default: begin
                if (end_full >= seq_addr) begin
                  state_nxt    = S_REQ;
                  req_op_nxt   = 2'b11;
                  req_addr_nxt = seq_addr;
                  req_end_nxt  = end_full;
                end else begin
                  state_nxt    = S_IDLE;
                  err_nxt      = 1'b1;
                  err_code_nxt = 2'b11;
                end
              end
            endcase
          end
        end else if (tmr_tc) begin
          state_nxt = S_IDLE;
          tmo_nxt   = 1'b1;
        end
      end

      S_REQ: begin
        if (word_vld) begin
          err_nxt      = 1'b1;
          err_code_nxt = 2'b10;
        end
        if (flash_ack)
          state_nxt = flash_done ? S_IDLE : S_BUSY;
      end

      S_BUSY: begin
        if (word_vld) begin
          err_nxt      = 1'b1;
          err_code_nxt = 2'b10;
        end
        if (flash_done)
          state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase

    // Returning to IDLE drops partial addresses and the finished request.
    if (state_nxt == S_IDLE) begin
      seq_addr_nxt = '0;
      end_hi_nxt   = '0;
      req_op_nxt   = 2'b00;
      req_addr_nxt = '0;
      req_end_nxt  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_addr      <= '0;
      end_hi        <= '0;
      wr_addr       <= '0;
      wr_addr_valid <= 1'b0;
      req_op        <= 2'b00;
      req_addr      <= '0;
      req_end_addr  <= '0;
      cmd_err       <= 1'b0;
      err_code      <= 2'b00;
      seq_timeout   <= 1'b0;
    end else begin
      seq_addr      <= seq_addr_nxt;
      end_hi        <= end_hi_nxt;
      wr_addr       <= wr_addr_nxt;
      wr_addr_valid <= wr_valid_nxt;
      req_op        <= req_op_nxt;
      req_addr      <= req_addr_nxt;
      req_end_addr  <= req_end_nxt;
      cmd_err       <= err_nxt;
      err_code      <= err_code_nxt;
      seq_timeout   <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_flash_cmd_dispatcher.sv
// Self-checking bench for flash_cmd_dispatcher. Words are checked against a
// sequence-matching reference model: the words of the current sequence are
// kept in a queue and compared with the legal command patterns.
module tb_flash_cmd_dispatcher;

  localparam int TMO = 24000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd;
  logic        start_cmd, flash_ack, flash_done;
  logic        req_valid, busy, cmd_err, seq_timeout;
  logic [1:0]  req_op, err_code;
  logic [23:0] req_addr, req_end_addr;

  always #5 clk = ~clk;

  flash_cmd_dispatcher #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .start_cmd(start_cmd),
    .flash_ack(flash_ack), .flash_done(flash_done),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_end_addr(req_end_addr), .busy(busy), .cmd_err(cmd_err),
    .err_code(err_code), .seq_timeout(seq_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor
  int         err_seen = 0;
  int         tmo_seen = 0;
  logic [1:0] err_code_seen = 2'b00;
  always @(negedge clk) begin
    if (cmd_err) begin
      err_seen++;
      err_code_seen = err_code;
    end
    if (seq_timeout) tmo_seen++;
  end

  // Reference model
  logic [31:0] seq_q[$];
  bit          wr_valid_m = 0;
  logic [23:0] wr_addr_m  = '0;
  bit          outstanding = 0;
  bit          in_req_m    = 0;
  int          exp_err;
  bit          exp_req;
  logic [1:0]  exp_op;
  logic [23:0] exp_addr, exp_end;

  function automatic logic [15:0] pat_hdr(input int p, input int i);
    case (p)
      0:       return {8'hAD, 8'(i)};
      1:       return {8'hAF, 8'(i)};
      2:       return {8'hAE, 8'(i)};
      default: return 16'hA000;
    endcase
  endfunction

  function automatic int pat_len(input int p);
    case (p)
      0, 1:    return 2;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  task automatic model_word(input logic [31:0] w);
    int          match;
    bit          ok;
    logic [23:0] s, e;
    exp_err = 0; exp_req = 0; exp_op = 2'b00; exp_addr = '0; exp_end = '0;
    if (outstanding) begin
      exp_err = 2;
      return;
    end
    seq_q.push_back(w);
    match = -1;
    for (int p = 0; p < 4; p++) begin
      ok = (seq_q.size() <= pat_len(p));
      for (int i = 0; i < seq_q.size(); i++)
        if (ok && seq_q[i][31:16] != pat_hdr(p, i)) ok = 0;
      if (ok) match = p;
    end
    if (match < 0) begin
      exp_err = 1;
      seq_q.delete();
      return;
    end
    if (seq_q.size() < pat_len(match)) return;
    case (match)
      0: begin
        exp_req = 1; exp_op = 2'b10;
        exp_addr = {seq_q[0][15:0], seq_q[1][15:8]};
      end
      1: begin
        wr_addr_m  = {seq_q[0][15:0], seq_q[1][15:8]};
        wr_valid_m = 1;
      end
      2: begin
        s = {seq_q[0][15:0], seq_q[1][15:8]};
        e = {seq_q[2][15:0], seq_q[3][15:8]};
        if (e >= s) begin
          exp_req = 1; exp_op = 2'b11; exp_addr = s; exp_end = e;
        end else exp_err = 3;
      end
      default: begin
        if (wr_valid_m) begin
          exp_req = 1; exp_op = 2'b01; exp_addr = wr_addr_m;
          wr_valid_m = 0;
        end else exp_err = 1;
      end
    endcase
    seq_q.delete();
    if (exp_req) begin
      outstanding = 1;
      in_req_m    = 1;
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [7:0] ops [5];
    ops = '{8'hAD, 8'hAF, 8'hAE, 8'hA0, 8'($urandom)};
    return {ops[$urandom_range(0, 4)], 8'($urandom_range(0, 3)), 16'($urandom)};
  endfunction

  // Called just after a negedge.
  task automatic send_word(input logic [31:0] w, input int hold);
    int e0;
    model_word(w);
    e0 = err_seen;
    cmd = w;
    start_cmd = 1'b1;
    repeat (hold) @(negedge clk);
    start_cmd = 1'b0;
    cmd = $urandom;
    repeat (3) @(negedge clk);
    check_val("err_pulses", err_seen - e0, (exp_err != 0));
    if (exp_err != 0) check_val("err_code", err_code_seen, exp_err);
    check_val("req_valid", req_valid, in_req_m);
    check_val("busy", busy, outstanding);
  endtask

  // mode: 0 ack then done, 1 ack then done with a rejected word, 2 ack+done together, <0 random
  task automatic handle_req(input logic [1:0] op, input logic [23:0] addr,
                            input logic [23:0] eaddr, input int mode);
    int m;
    m = (mode < 0) ? $urandom_range(0, 2) : mode;
    check_val("req_valid_up", req_valid, 1);
    check_val("busy_up", busy, 1);
    check_val("req_op", req_op, op);
    check_val("req_addr", req_addr, addr);
    check_val("req_end_addr", req_end_addr, eaddr);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    check_val("req_hold", req_valid, 1);
    if (m == 1) send_word(32'hAD00_0000, 1);
    if (m == 2) begin
      flash_ack = 1'b1; flash_done = 1'b1;
      @(negedge clk);
      flash_ack = 1'b0; flash_done = 1'b0;
      outstanding = 0; in_req_m = 0;
      check_val("ackdone_valid", req_valid, 0);
      check_val("ackdone_busy", busy, 0);
      check_val("ackdone_op", req_op, 0);
    end else begin
      flash_ack = 1'b1;
      @(negedge clk);
      flash_ack = 1'b0;
      in_req_m = 0;
      check_val("ack_valid", req_valid, 0);
      check_val("ack_busy", busy, 1);
      check_val("ack_op", req_op, op);
      if (m == 1) send_word(32'hAD00_0000, 2);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      flash_done = 1'b1;
      @(negedge clk);
      flash_done = 1'b0;
      outstanding = 0;
      check_val("done_busy", busy, 0);
      check_val("done_op", req_op, 0);
    end
  endtask

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          e0, t0, cyc, p;
    logic [31:0] w;

    rst = 1'b1; cmd = '0; start_cmd = 1'b0; flash_ack = 1'b0; flash_done = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_outputs",
              {req_valid, req_op, req_addr, req_end_addr, busy, cmd_err, err_code, seq_timeout}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_outputs",
              {req_valid, req_op, req_addr, req_end_addr, busy, cmd_err, err_code, seq_timeout}, 0);

    // Read with held strobe and latency check
    send_word(32'hAD00_0102, 4);
    model_word(32'hAD01_0300);
    e0 = err_seen;
    cmd = 32'hAD01_0300; start_cmd = 1'b1;
    @(negedge clk);
    check_val("lat_1clk", req_valid, 0);
    @(negedge clk);
    check_val("lat_2clk", req_valid, 1);
    repeat (2) @(negedge clk);
    start_cmd = 1'b0;
    repeat (3) @(negedge clk);
    check_val("held_one_word", err_seen - e0, 0);
    handle_req(2'b10, 24'h010203, 24'h0, 0);

    // Write, then a second write-start without an address
    send_word(32'hAF00_0102, 1);
    send_word(32'hAF01_0300, 2);
    send_word(32'hA000_0000, 1);
    handle_req(2'b01, 24'h010203, 24'h0, 0);
    send_word(32'hA000_0000, 1);
    check_val("wgo_twice_code", err_code_seen, 2'b01);

    // Erase, then swapped range
    send_word(32'hAE00_0001, 1);
    send_word(32'hAE01_0000, 1);
    send_word(32'hAE02_0002, 1);
    send_word(32'hAE03_FF00, 1);
    handle_req(2'b11, 24'h000100, 24'h0002FF, 2);
    send_word(32'hAE00_0002, 1);
    send_word(32'hAE01_FF00, 1);
    send_word(32'hAE02_0001, 1);
    send_word(32'hAE03_0000, 1);
    check_val("erase_swap_code", err_code_seen, 2'b11);

    // Busy rejection, then a fresh read
    send_word(32'hAD00_1234, 1);
    send_word(32'hAD01_5600, 1);
    handle_req(2'b10, 24'h123456, 24'h0, 1);
    send_word(32'hAD00_ABCD, 3);
    send_word(32'hAD01_EF77, 1);
    handle_req(2'b10, 24'hABCDEF, 24'h0, 0);

    // Sequence stall timeout
    t0 = tmo_seen;
    send_word(32'hAD00_0000, 1);
    cyc = 4;
    while (tmo_seen == t0 && cyc < TMO + 100) begin
      @(negedge clk);
      cyc++;
    end
    check_val("tmo_seen", tmo_seen - t0, 1);
    check_val("tmo_latency_ok", (cyc >= TMO && cyc <= TMO + 5), 1);
    @(negedge clk);
    @(negedge clk);
    check_val("tmo_pulse_width", tmo_seen - t0, 1);
    seq_q.delete();
    send_word(32'hAD01_0000, 1);
    check_val("after_tmo_code", err_code_seen, 2'b01);

    // A word arriving just before the limit keeps the sequence alive
    t0 = tmo_seen;
    send_word(32'hAD00_4242, 1);
    repeat (TMO - 30) @(negedge clk);
    send_word(32'hAD01_4200, 1);
    check_val("near_tmo_none", tmo_seen - t0, 0);
    handle_req(2'b10, 24'h424242, 24'h0, 0);

    // Randomized sequences
    for (int s = 0; s < 80; s++) begin
      p = $urandom_range(0, 3);
      for (int i = 0; i < pat_len(p); i++) begin
        w = {pat_hdr(p, i), 16'($urandom)};
        if ($urandom_range(0, 9) == 0) w = rand_word();
        if ($urandom_range(0, 9) == 0) begin
          flash_done = 1'b1;
          @(negedge clk);
          flash_done = 1'b0;
        end
        send_word(w, $urandom_range(1, 4));
        if (outstanding) handle_req(exp_op, exp_addr, exp_end, -1);
      end
    end
    check_val("no_stray_timeout", tmo_seen, 1);

    // Reset while a request is pending
    seq_q.delete();
    send_word(32'hAD00_0000, 1);
    send_word(32'hAD00_0000, 1);
    send_word(32'hAD00_0099, 1);
    send_word(32'hAD01_9900, 1);
    check_val("pre_rst_req", req_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_val("rst_req_valid", req_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_op_addr", {req_op, req_addr}, 0);
    @(negedge clk);
    rst = 1'b0;
    seq_q.delete(); wr_valid_m = 0; outstanding = 0; in_req_m = 0;
    @(negedge clk);
    send_word(32'hA000_0000, 1);
    check_val("rst_wr_valid_cleared", err_code_seen, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
